// File: rtl/echo_capture.sv
// echo_capture: trigger generator and echo pulse-width timer for one
// HC-SR04-class ultrasonic ranger; results held until the next DONE.
module echo_capture #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int HOLDOFF_CYCLES = 6000000,
  parameter int CNT_W          = 22
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ECHO,
  output logic             TRIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] WIDTH
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_N = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] TO_N   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLDOFF_CYCLES);

  state_t           state;
  logic             echo_m;
  logic             echo_s;
  logic             echo_d;
  logic [CNT_W-1:0] seq_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] to_nxt;
  logic             rise;
  logic             fall;
  logic             timing;
  logic             abort;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= ECHO;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise   = echo_s & ~echo_d;
  assign fall   = ~echo_s & echo_d;
  assign to_nxt = to_cnt + ONE;

  // Timeout runs while arming or listening; a fall in the
  // expiring cycle still counts as a valid measurement.
  assign timing = (state == S_ARM && echo_s)
               || (state == S_WAIT_RISE)
               || (state == S_MEASURE && !fall);
  assign abort  = timing && (to_nxt == TO_N);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      TRIG    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      TIMEOUT <= 1'b0;
      WIDTH   <= '0;
      seq_cnt <= '0;
      to_cnt  <= '0;
      w_cnt   <= '0;
    end else begin
      DONE <= 1'b0;
      if (abort) begin
        state   <= S_HOLDOFF;
        TIMEOUT <= 1'b1;
        WIDTH   <= '0;
        DONE    <= 1'b1;
        seq_cnt <= '0;
      end else begin
        if (timing) to_cnt <= to_nxt;
        unique case (state)
          S_IDLE: begin
            if (START) begin
              state  <= S_ARM;
              BUSY   <= 1'b1;
              to_cnt <= '0;
            end
          end
          S_ARM: begin
            if (!echo_s) begin
              state   <= S_TRIG;
              TRIG    <= 1'b1;
              seq_cnt <= ONE;
            end
          end
          S_TRIG: begin
            if (seq_cnt == TRIG_N) begin
              state  <= S_WAIT_RISE;
              TRIG   <= 1'b0;
              to_cnt <= '0;
            end else begin
              seq_cnt <= seq_cnt + ONE;
            end
          end
          S_WAIT_RISE: begin
            if (rise) begin
              state <= S_MEASURE;
              w_cnt <= ONE;
            end
          end
          S_MEASURE: begin
            if (fall) begin
              state   <= S_HOLDOFF;
              WIDTH   <= w_cnt;
              TIMEOUT <= 1'b0;
              DONE    <= 1'b1;
              seq_cnt <= '0;
            end else if (echo_s) begin
              w_cnt <= w_cnt + ONE;
            end
          end
          S_HOLDOFF: begin
            if (seq_cnt == HOLD_N) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else begin
              seq_cnt <= seq_cnt + ONE;
            end
          end
          default: begin
            state <= S_IDLE;
            TRIG  <= 1'b0;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_echo_capture.sv
// tb_echo_capture: vector table, corner sequences and random runs
// checked against a cycle-level latency/timeout model.
module tb_echo_capture;

  localparam int TC = 4;
  localparam int TO = 100;
  localparam int HO = 10;
  localparam int W  = 22;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         echo;
  logic         trig;
  logic         busy;
  logic         done;
  logic         tmo;
  logic [W-1:0] width;

  int errors = 0;
  int checks = 0;
  int prev_w = 0;
  bit prev_to = 1'b0;

  always #5 clk = ~clk;

  echo_capture #(
    .TRIG_CYCLES(TC),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO),
    .CNT_W(W)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .START(start),
    .ECHO(echo),
    .TRIG(trig),
    .BUSY(busy),
    .DONE(done),
    .TIMEOUT(tmo),
    .WIDTH(width)
  );

  typedef struct {
    int    d;
    int    len;
    bit    stuck;
    bit    poke;
    int    w;
    bit    to;
    string tag;
  } vec_t;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("idle_wait", int'(busy), 0);
  endtask

  // Pad edges reach the detector 3 edges late; an echo counts only
  // if its fall is seen no later than TO edges after TRIG ends.
  function automatic bit ref_valid(input int d, input int len,
                                   input bit stuck);
    return !stuck && len > 0 && (d + len + 3 <= TO);
  endfunction

  task automatic run_meas(input int d, input int len, input bit stuck,
                          input bit poke, input int xw, input bit xto,
                          input string tag);
    int e;
    int tfirst;
    int tn;
    int dn;
    int xdone;
    int tfall;
    int cw;
    bit ct;
    bit held_ok;
    bit valid;
    wait_idle();
    if (stuck) begin
      echo = 1'b1;
      repeat (3) tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":busy_on"}, int'(busy), 1);
    e = -1;
    tfirst = -1;
    tn = 0;
    dn = 0;
    tfall = -1;
    held_ok = 1'b1;
    valid = ref_valid(d, len, stuck);
    xdone = stuck ? TO : -1;
    for (int t = 1; t <= 400; t++) begin
      start = poke && ($urandom_range(0, 2) == 0);
      if (stuck) echo = (dn == 0);
      else echo = (e >= 0 && t >= e + d + 1 && t <= e + d + len);
      tick();
      if (trig) begin
        tn++;
        if (tfirst < 0) tfirst = t;
      end else if (tfirst >= 0 && e < 0) begin
        e = t;
        xdone = valid ? e + d + len + 3 : e + TO;
      end
      if (done) begin
        dn++;
        chk({tag, ":done_time"}, t, xdone);
        chk({tag, ":width"}, int'(width), xw);
        chk({tag, ":timeout"}, int'(tmo), int'(xto));
      end
      cw = (dn > 0) ? xw : prev_w;
      ct = (dn > 0) ? xto : prev_to;
      if (int'(width) != cw || tmo !== ct) held_ok = 1'b0;
      if (!busy) begin
        tfall = t;
        break;
      end
    end
    start = 1'b0;
    echo = 1'b0;
    chk({tag, ":done_count"}, dn, 1);
    chk({tag, ":trig_len"}, tn, stuck ? 0 : TC);
    chk({tag, ":trig_start"}, tfirst, stuck ? -1 : 1);
    chk({tag, ":busy_fall"}, tfall, xdone + HO + 1);
    chk({tag, ":held"}, int'(held_ok), 1);
    prev_w = xw;
    prev_to = xto;
  endtask

  vec_t vecs[8];
  int   dn;
  bit   busy_seen;
  int   rd;
  int   rl;
  bit   rp;
  bit   rv;

  initial begin
    vecs = '{
      '{5, 37, 1'b0, 1'b0, 37, 1'b0, "nominal"},
      '{0, 0, 1'b0, 1'b0, 0, 1'b1, "no_echo"},
      '{3, 20, 1'b0, 1'b0, 20, 1'b0, "after_to"},
      '{0, 0, 1'b1, 1'b0, 0, 1'b1, "stuck"},
      '{2, 30, 1'b0, 1'b1, 30, 1'b0, "poke"},
      '{5, 92, 1'b0, 1'b0, 92, 1'b0, "edge_fall"},
      '{5, 93, 1'b0, 1'b0, 0, 1'b1, "edge_late"},
      '{0, 1, 1'b0, 1'b0, 1, 1'b0, "short"}
    };
    rst = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(tmo), 0);
    chk("rst_width", int'(width), 0);
    repeat (5) tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_trig", int'(trig), 0);
    chk("idle_done", int'(done), 0);

    foreach (vecs[i])
      run_meas(vecs[i].d, vecs[i].len, vecs[i].stuck, vecs[i].poke,
               vecs[i].w, vecs[i].to, vecs[i].tag);

    // Reset in the middle of a measurement
    wait_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    echo = 1'b1;
    repeat (12) tick();
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_trig", int'(trig), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_width", int'(width), 0);
    chk("mid_rst_timeout", int'(tmo), 0);
    prev_w = 0;
    prev_to = 1'b0;
    dn = 0;
    busy_seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t == 5) echo = 1'b0;
      tick();
      if (done) dn++;
      if (busy) busy_seen = 1'b1;
    end
    chk("mid_rst_no_done", dn, 0);
    chk("mid_rst_no_busy", int'(busy_seen), 0);
    run_meas(5, 37, 1'b0, 1'b0, 37, 1'b0, "post_rst");

    for (int i = 0; i < 10; i++) begin
      rd = $urandom_range(0, 20);
      rl = $urandom_range(0, 90);
      rp = 1'($urandom_range(0, 1));
      rv = ref_valid(rd, rl, 1'b0);
      run_meas(rd, rl, 1'b0, rp, rv ? rl : 0, !rv, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
